// File: rtl/pcm_to_pwm_multi.sv
// pcm_to_pwm_multi: multi-channel PCM-to-PWM converter on the pwm_clk domain.
// Frames arrive over valid/ready into a one-deep pending buffer and are moved
// into the active duty registers only at a PWM period boundary.
// Optional build macro: PCM_TO_PWM_SIGNED_EN (two's complement input samples).
module pcm_to_pwm_multi #(
  parameter int unsigned BIT_DEPTH        = 8,
  parameter int unsigned NUM_CH           = 2,
  parameter bit          HOLD_ON_UNDERRUN = 1'b1
) (
  input  logic                        pwm_clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NUM_CH*BIT_DEPTH-1:0] pcm_data,
  input  logic                        pcm_valid,
  output logic                        pcm_ready,
  output logic [NUM_CH-1:0]           pwm_out,
  output logic                        period_start,
  output logic                        underrun,
  output logic                        running
);

  localparam int unsigned             FRAME_W  = NUM_CH * BIT_DEPTH;
  localparam logic [BIT_DEPTH-1:0]    MIDSCALE = {1'b1, {(BIT_DEPTH-1){1'b0}}};
  localparam logic [BIT_DEPTH-1:0]    LAST     = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [BIT_DEPTH-1:0] count;
  logic [FRAME_W-1:0]   pending;
  logic [FRAME_W-1:0]   active;
  logic [FRAME_W-1:0]   frame_in;
  logic [FRAME_W-1:0]   midscale_frame;
  logic [NUM_CH-1:0]    hit;
  logic                 pending_full;
  logic                 accept;
  logic                 load;
  logic                 starve;
  logic                 run_now;

  assign pcm_ready      = !pending_full;
  assign accept         = pcm_valid && pcm_ready;
  assign running        = (state == RUN);
  assign run_now        = (state == RUN) && en;
  assign midscale_frame = {NUM_CH{MIDSCALE}};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
`ifdef PCM_TO_PWM_SIGNED_EN
    // Flipping the sign bit turns two's complement into offset binary.
    assign frame_in[c*BIT_DEPTH +: BIT_DEPTH] =
      {~pcm_data[c*BIT_DEPTH + BIT_DEPTH - 1], pcm_data[c*BIT_DEPTH +: BIT_DEPTH-1]};
`else
    assign frame_in[c*BIT_DEPTH +: BIT_DEPTH] = pcm_data[c*BIT_DEPTH +: BIT_DEPTH];
`endif
    assign hit[c] = count < active[c*BIT_DEPTH +: BIT_DEPTH];
  end

  // State register.
  always_ff @(posedge pwm_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus the load/underrun decisions taken at period boundaries.
  // Dropping en takes priority over a boundary falling in the same cycle.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    starve     = 1'b0;
    case (state)
      IDLE: begin
        if (en && pending_full) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_next = IDLE;
        end else if (count == LAST) begin
          if (pending_full) begin
            load = 1'b1;
          end else begin
            starve = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Period counter, pending buffer and active duty registers.
  // Accept and load never coincide: accept needs pending empty, load needs it full.
  always_ff @(posedge pwm_clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      active       <= '0;
    end else begin
      count <= run_now ? count + 1'b1 : '0;
      if (accept) begin
        pending      <= frame_in;
        pending_full <= 1'b1;
      end else if (load) begin
        pending_full <= 1'b0;
      end
      if (load) begin
        active <= pending;
      end else if (starve && !HOLD_ON_UNDERRUN) begin
        active <= midscale_frame;
      end
    end
  end

  // Registered outputs; pwm_out and period_start lag count by one cycle.
  always_ff @(posedge pwm_clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      pwm_out      <= run_now ? hit : '0;
      period_start <= run_now && (count == '0);
      underrun     <= starve;
    end
  end

endmodule
